// File: rtl/y_arith_pkg.sv
// -----------------------------------------------------------------------------
// y_arith_pkg
// Shared definitions for the digit-serial subtractor slice.
//   WIDTH_DEF / DIGIT_DEF : default operand width and bits processed per cycle
//   state_t               : sequencer states (IDLE, RUN, DONE)
//   cnt_bits()            : width of a counter able to index n digits (min 1)
// -----------------------------------------------------------------------------
package y_arith_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned DIGIT_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/y_serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// y_serial_subtractor_if
// Request/result bundle of the serial subtractor.
//   start, a, b, bin : request (master -> slave)
//   z, bout          : result, valid from the done pulse onward
//   busy, done       : status (busy while digits are processed, done one cycle)
//   v                : signed overflow, only when OVERFLOW_FLAG_EN is defined
// -----------------------------------------------------------------------------
interface y_serial_subtractor_if
   import y_arith_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic [WIDTH-1:0] z;
   logic             bout;
   logic             busy;
   logic             done;
`ifdef OVERFLOW_FLAG_EN
   logic             v;
`endif

   modport master (
      output start, a, b, bin,
      input  z, bout, busy, done
`ifdef OVERFLOW_FLAG_EN
      , v
`endif
   );

   modport slave (
      input  start, a, b, bin,
      output z, bout, busy, done
`ifdef OVERFLOW_FLAG_EN
      , v
`endif
   );

endinterface

// File: rtl/y_digit_adder.sv
// -----------------------------------------------------------------------------
// y_digit_adder
// Combinational DIGIT-bit ripple-carry adder.
//   x_i, y_i : addend digits
//   c_i      : carry in
//   s_o      : sum digit
//   c_o      : carry out of the digit MSB
// -----------------------------------------------------------------------------
module y_digit_adder #(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] x_i,
   input  logic [DIGIT-1:0] y_i,
   input  logic             c_i,
   output logic [DIGIT-1:0] s_o,
   output logic             c_o
);

   always_comb begin : ripple
      logic c;
      c   = c_i;
      s_o = '0;
      for (int unsigned k = 0; k < DIGIT; k++) begin
         s_o[k] = x_i[k] ^ y_i[k] ^ c;
         c      = (x_i[k] & y_i[k]) | (c & (x_i[k] ^ y_i[k]));
      end
      c_o = c;
   end

endmodule

// File: rtl/y_serial_subtractor.sv
// -----------------------------------------------------------------------------
// y_serial_subtractor
// Digit-serial subtractor: z = a - b - bin (mod 2^WIDTH), computed as
// a + ~b + ~bin, DIGIT bits per cycle, LSB digit first.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : y_serial_subtractor_if.slave (start/a/b/bin in, z/bout/busy/done out)
// Optional: define OVERFLOW_FLAG_EN to add bus.v, the signed overflow flag,
// valid and held together with z.
// Latency from accepted start to done pulse is WIDTH/DIGIT + 1 cycles.
// WIDTH must be a multiple of DIGIT.
// -----------------------------------------------------------------------------
module y_serial_subtractor
   import y_arith_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DIGIT = DIGIT_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   y_serial_subtractor_if.slave bus
);

   localparam int unsigned   NDIG = WIDTH / DIGIT;
   localparam int unsigned   CW   = cnt_bits(NDIG);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;     // partial result, digits enter at the top
   logic [WIDTH-1:0] z_q, z_d;
   logic             carry_q, carry_d;
   logic             bout_q, bout_d;
`ifdef OVERFLOW_FLAG_EN
   logic             sa_q, sa_d;   // operand sign bits kept for the flag
   logic             sb_q, sb_d;
   logic             v_q, v_d;
`endif

   logic [DIGIT-1:0] sum;
   logic             sum_c;

   // Operands are shifted right each RUN cycle, so the current digit is
   // always the low DIGIT bits.
   y_digit_adder #(.DIGIT(DIGIT)) u_digit (
      .x_i (a_q[DIGIT-1:0]),
      .y_i (~b_q[DIGIT-1:0]),
      .c_i (carry_q),
      .s_o (sum),
      .c_o (sum_c)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      z_d     = z_q;
      carry_d = carry_q;
      bout_d  = bout_q;
`ifdef OVERFLOW_FLAG_EN
      sa_d    = sa_q;
      sb_d    = sb_q;
      v_d     = v_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = ~bus.bin;
               cnt_d   = '0;
               state_d = RUN;
`ifdef OVERFLOW_FLAG_EN
               sa_d    = bus.a[WIDTH-1];
               sb_d    = bus.b[WIDTH-1];
`endif
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            carry_d = sum_c;
            // Shift-in form rather than a concatenation so DIGIT == WIDTH works.
            r_d     = (r_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
               z_d     = r_d;
               bout_d  = ~sum_c;
`ifdef OVERFLOW_FLAG_EN
               // a and ~b share a sign only when a and b differ in sign;
               // overflow is then a result sign differing from a's.
               v_d     = (sa_q != sb_q) && (sum[DIGIT-1] != sa_q);
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         z_q     <= '0;
         carry_q <= 1'b0;
         bout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         v_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         z_q     <= z_d;
         carry_q <= carry_d;
         bout_q  <= bout_d;
`ifdef OVERFLOW_FLAG_EN
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         v_q     <= v_d;
`endif
      end
   end

   assign bus.z    = z_q;
   assign bus.bout = bout_q;
   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
`ifdef OVERFLOW_FLAG_EN
   assign bus.v    = v_q;
`endif

endmodule

// File: tb/tb_y_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_y_serial_subtractor
// Directed vector table plus hand-written multi-cycle sequences for the
// serial subtractor at WIDTH=32, DIGIT=4. Checks v when OVERFLOW_FLAG_EN is set.
// -----------------------------------------------------------------------------
module tb_y_serial_subtractor;

   localparam int unsigned W    = 32;
   localparam int unsigned D    = 4;
   localparam int unsigned NDIG = W / D;
   localparam int          LAT  = NDIG + 1;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   y_serial_subtractor_if #(.WIDTH(W)) bus ();

   y_serial_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        bin;
      logic [31:0] z;
      logic        bout;
      logic        v;
   } vec_t;

   vec_t vecs [10];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a request for exactly one edge; returns just after that edge.
   task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic bin);
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
   endtask

   // edges counts clock edges since (and including) the start edge.
   task automatic wait_done(input int already, output int edges);
      edges = already;
      for (int i = 0; i < 30; i++) begin
         step();
         edges++;
         if (bus.done === 1'b1) break;
      end
   endtask

   initial begin
      int          lat;
      int          dcount;
      logic [31:0] ra, rb;
      logic        rbin;
      logic [32:0] ud;
      logic [33:0] sd;

      vecs[0] = '{32'd5,         32'd3,         1'b0, 32'd2,         1'b0, 1'b0};
      vecs[1] = '{32'd0,         32'd1,         1'b0, 32'hFFFFFFFF,  1'b1, 1'b0};
      vecs[2] = '{32'd0,         32'd0,         1'b1, 32'hFFFFFFFF,  1'b1, 1'b0};
      vecs[3] = '{32'h80000000,  32'd1,         1'b0, 32'h7FFFFFFF,  1'b0, 1'b1};
      vecs[4] = '{32'h7FFFFFFF,  32'hFFFFFFFF,  1'b0, 32'h80000000,  1'b1, 1'b1};
      vecs[5] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF,  1'b1, 1'b0};
      vecs[6] = '{32'h12345678,  32'h12345678,  1'b0, 32'h00000000,  1'b0, 1'b0};
      vecs[7] = '{32'h00000010,  32'h0000000F,  1'b1, 32'h00000000,  1'b0, 1'b0};
      vecs[8] = '{32'hA5A5A5A5,  32'h5A5A5A5A,  1'b0, 32'h4B4B4B4B,  1'b0, 1'b1};
      vecs[9] = '{32'h80000000,  32'd0,         1'b1, 32'h7FFFFFFF,  1'b0, 1'b1};

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      step();
      step();
      check("reset_z",    bus.z,    0);
      check("reset_bout", bus.bout, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_done", bus.done, 0);
`ifdef OVERFLOW_FLAG_EN
      check("reset_v",    bus.v,    0);
`endif

      // reset wins over a simultaneous start
      launch(32'd5, 32'd3, 1'b0);
      check("reset_over_start_busy", bus.busy, 0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 10; i++) begin
         launch(vecs[i].a, vecs[i].b, vecs[i].bin);
         check("vec_busy", bus.busy, 1);
         wait_done(1, lat);
         check("vec_latency", 64'(lat), 64'(LAT));
         check("vec_z",    bus.z,    vecs[i].z);
         check("vec_bout", bus.bout, vecs[i].bout);
`ifdef OVERFLOW_FLAG_EN
         check("vec_v",    bus.v,    vecs[i].v);
`endif
         step();
         check("vec_done_pulse", bus.done, 0);
         check("vec_busy_after", bus.busy, 0);
         check("vec_z_held",     bus.z,    vecs[i].z);
      end

      // start with new operands mid-RUN must be ignored
      launch(32'd5, 32'd3, 1'b0);
      step();
      step();
      bus.a     = 32'h00001000;
      bus.b     = 32'd1;
      bus.bin   = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.a     = 32'hFFFF0000;
      wait_done(4, lat);
      check("midrun_latency", 64'(lat), 64'(LAT));
      check("midrun_z",    bus.z,    32'd2);
      check("midrun_bout", bus.bout, 0);
      step();
      check("midrun_no_restart", bus.busy, 0);

      // back-to-back: start accepted in the DONE cycle
      launch(32'd100, 32'd1, 1'b0);
      wait_done(1, lat);
      check("b2b_first_done", bus.done, 1);
      check("b2b_first_z",    bus.z,    32'd99);
      launch(32'd50, 32'd8, 1'b1);
      check("b2b_second_busy", bus.busy, 1);
      wait_done(1, lat);
      check("b2b_second_latency", 64'(lat), 64'(LAT));
      check("b2b_second_z",    bus.z,    32'd41);
      check("b2b_second_bout", bus.bout, 0);
      step();

      // reset during RUN cycle 4 aborts without a done pulse
      launch(32'h00001234, 32'h00000034, 1'b0);
      step();
      step();
      step();
      check("abort_busy_before", bus.busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_z",    bus.z,    0);
      check("abort_bout", bus.bout, 0);
      check("abort_done", bus.done, 0);
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.done === 1'b1) dcount++;
      end
      check("abort_no_done", 64'(dcount), 0);

      // random operands against a wide-arithmetic reference
      for (int i = 0; i < 10; i++) begin
         ra   = $urandom;
         rb   = $urandom;
         rbin = 1'($urandom_range(0, 1));
         ud   = {1'b0, ra} - {1'b0, rb} - 33'(rbin);
         sd   = {{2{ra[31]}}, ra} - {{2{rb[31]}}, rb} - 34'(rbin);
         launch(ra, rb, rbin);
         wait_done(1, lat);
         check("rand_latency", 64'(lat), 64'(LAT));
         check("rand_z",    bus.z,    ud[31:0]);
         check("rand_bout", bus.bout, ud[32]);
`ifdef OVERFLOW_FLAG_EN
         check("rand_v", bus.v, !(sd[33:31] == 3'b000 || sd[33:31] == 3'b111));
`endif
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
